buffer_dispatcher: RTL

BUFFER_DISPATCHER -- requirements
Module: buffer_dispatcher

---
 rtl/buffer_dispatcher.sv | 102 ++++++++++
 1 files changed

// File: rtl/buffer_dispatcher.sv
// Pops entries from an upstream circular buffer and presents them one at a time
// to a valid/ready consumer, while tracking how many entries are still queued.
module buffer_dispatcher #(
    parameter int  size = 16,
    parameter type T    = logic [31:0]
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_seen,
    input  logic                    flush,
    output logic                    pop_buffer,
    input  T                        buffer_data,
    output logic                    out_valid,
    output T                        out_data,
    input  logic                    out_ready,
    output logic [$clog2(size):0]   count,
    output logic                    drained,
    output logic                    overflow_err
);

    localparam int CW = $clog2(size) + 1;
    localparam logic [CW-1:0] FULL = CW'(size);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT,
        HOLD
    } state_t;

    state_t state;
    logic   popping;

    assign popping = (state == POP);
    assign drained = (count == '0) && (state == IDLE);

    // pop_buffer and out_valid are registered alongside the state so that
    // they exactly track POP and HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            pop_buffer   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            count      <= '0;
            pop_buffer <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            pop_buffer <= 1'b0;

            unique case ({push_seen, popping})
                2'b10: begin
                    if (count == FULL)
                        overflow_err <= 1'b1;
                    else
                        count <= count + 1'b1;
                end
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            // Transitions look at count before this edge's update.
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= POP;
                        pop_buffer <= 1'b1;
                    end
                end
                POP: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    out_data  <= buffer_data;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (count != '0) begin
                            state      <= POP;
                            pop_buffer <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
